// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU,
// branch/jump resolution with same-cycle redirect, and the EX/MEM register.
module execute_stage #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC_PLUS4 = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            MemReadE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic [2:0]      Funct3E,
    input  logic [3:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,

    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,

    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            MemReadM,
    output logic            ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RD_M
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSB = 4'b1010,
        ALU_ADDPC = 4'b1011
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_e;

    typedef enum logic [1:0] {
        FWD_RD  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] exec_result;
    logic [XLEN-1:0] jalr_sum;
    logic [4:0]      shamt;
    logic            cmp_eq;
    logic            cmp_lt;
    logic            cmp_ltu;
    logic            branch_taken;
    alu_op_e         alu_op;

    // Forwarding: the MEM-stage source is the registered ALUResultM itself.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        src_a = RD1_E;
        case (fwd_sel_e'(ForwardAE))
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        write_data_e = RD2_E;
        case (fwd_sel_e'(ForwardBE))
            FWD_WB:  write_data_e = ResultW;
            FWD_MEM: write_data_e = ALUResultM;
            default: write_data_e = RD2_E;
        endcase
    end

    assign src_b  = ALUSrcE ? Imm_Ext_E : write_data_e;
    assign shamt  = src_b[4:0];
    assign alu_op = alu_op_e'(ALUControlE);

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD:   alu_result = src_a + src_b;
            ALU_SUB:   alu_result = src_a - src_b;
            ALU_SLL:   alu_result = src_a << shamt;
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_XOR:   alu_result = src_a ^ src_b;
            ALU_SRL:   alu_result = src_a >> shamt;
            ALU_SRA:   alu_result = $signed(src_a) >>> shamt;
            ALU_OR:    alu_result = src_a | src_b;
            ALU_AND:   alu_result = src_a & src_b;
            ALU_PASSB: alu_result = src_b;
            ALU_ADDPC: alu_result = PCE + src_b;
            default:   alu_result = '0;
        endcase
    end

    // Branches compare the two register operands, never the immediate.
    assign cmp_eq  = (src_a == write_data_e);
    assign cmp_lt  = ($signed(src_a) < $signed(write_data_e));
    assign cmp_ltu = (src_a < write_data_e);

    always_comb begin
        branch_taken = 1'b0;
        case (branch_e'(Funct3E))
            BR_BEQ:  branch_taken = cmp_eq;
            BR_BNE:  branch_taken = ~cmp_eq;
            BR_BLT:  branch_taken = cmp_lt;
            BR_BGE:  branch_taken = ~cmp_lt;
            BR_BLTU: branch_taken = cmp_ltu;
            BR_BGEU: branch_taken = ~cmp_ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    assign jalr_sum  = src_a + Imm_Ext_E;
    assign PCSrcE    = (BranchE & branch_taken) | JumpE;
    assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + Imm_Ext_E);

    // Jumps write the link address instead of the ALU result.
    assign exec_result = JumpE ? PCPlus4E : alu_result;

    // NOTE: pipeline state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemReadM   <= 1'b0;
            ResultSrcM <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= RESET_PC_PLUS4;
            RD_M       <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            MemReadM   <= MemReadE;
            ResultSrcM <= ResultSrcE;
            ALUResultM <= exec_result;
            WriteDataM <= write_data_e;
            PCPlus4M   <= PCPlus4E;
            RD_M       <= RD_E;
        end
    end

endmodule
